// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external combinational adder among
// NUM_REQ requesters. At most one requester is granted per cycle. Its operands
// go out to the adder, and the sum comes back registered one cycle later,
// tagged one-hot to the requester that was granted.

// Per-requester operand gate: passes the operands only when this lane is granted,
// so the top level can OR-reduce all lanes into the shared adder inputs.
module adder_arbiter_lane #(
  parameter int WIDTH = 16
) (
  input  logic             gnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_m,
  output logic [WIDTH-1:0] b_m
);
  assign a_m = gnt ? a : '0;
  assign b_m = gnt ? b : '0;
endmodule

module adder_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic                     stall,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data
);

  logic [PTR_W-1:0]                  prio_ptr;
  logic [PTR_W-1:0]                  sel;
  logic [PTR_W-1:0]                  nxt_ptr;
  logic                              hit;
  int                                idx;
  logic [NUM_REQ-1:0][WIDTH-1:0]     ops_a, ops_b;
  logic [NUM_REQ-1:0][WIDTH-1:0]     msk_a, msk_b;

  assign ops_a = req_a;
  assign ops_b = req_b;

  // Cyclic priority scan starting at prio_ptr. The loop runs from the farthest
  // position back toward prio_ptr, so the last match written is the nearest one.
  // Reset and stall both suppress the grant.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = 0;
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(prio_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        sel = PTR_W'(idx);
        hit = 1'b1;
      end
    end
    if (hit && !stall && !rst) gnt[sel] = 1'b1;
  end

  // The pointer moves to the slot just past the winner. The last slot wraps to 0.
  assign nxt_ptr = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    adder_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt (gnt[i]),
      .a   (ops_a[i]),
      .b   (ops_b[i]),
      .a_m (msk_a[i]),
      .b_m (msk_b[i])
    );
  end

  // OR-merge the gated lanes. Because the grant is one-hot, this acts as a mux,
  // and the result is zero when no requester is granted.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      add_a = add_a | msk_a[i];
      add_b = add_b | msk_b[i];
    end
  end

  // Capture the sum one cycle after the grant and advance the pointer. When there
  // is no grant, the data and the pointer hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= gnt;
      if (|gnt) begin
        rsp_data <= add_result;
        prio_ptr <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter. A table of per-cycle vectors is applied,
// and each row is checked against hand-computed values. Hand-written sequences
// cover reset during a pending response and operand changes after a grant.
module tb_adder_arbiter;
  localparam int W = 16;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic           stall;
  logic [N-1:0]   gnt;
  logic [W-1:0]   add_a, add_b, add_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Model of the external shared adder (carry-out dropped).
  assign add_result = add_a + add_b;

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .stall(stall), .gnt(gnt), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  typedef struct {
    logic         rst;
    logic         stall;
    logic [2:0]   req;
    logic [47:0]  a;
    logic [47:0]  b;
    logic [2:0]   xg;
    logic [15:0]  xa;
    logic [15:0]  xb;
    logic [2:0]   xrv;
    logic [15:0]  xrd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand sets: {req2, req1, req0}
  localparam logic [47:0] A1 = {16'h0000, 16'h0000, 16'h0022};
  localparam logic [47:0] B1 = {16'h0000, 16'h0000, 16'h10A4};
  localparam logic [47:0] A2 = {16'h1100, 16'hEE00, 16'h0020};
  localparam logic [47:0] B2 = {16'h1001, 16'h00FF, 16'h0101};
  localparam logic [47:0] A3 = {16'hFFFF, 16'h0003, 16'h0001};
  localparam logic [47:0] B3 = {16'h0001, 16'h0004, 16'h0002};

  function automatic vec_t mk(logic r, logic s, logic [2:0] q, logic [47:0] a, logic [47:0] b,
                              logic [2:0] g, logic [15:0] xa, logic [15:0] xb,
                              logic [2:0] rv, logic [15:0] rd);
    vec_t v;
    v.rst = r; v.stall = s; v.req = q; v.a = a; v.b = b;
    v.xg = g; v.xa = xa; v.xb = xb; v.xrv = rv; v.xrd = rd;
    return v;
  endfunction

  initial begin
    // Columns: rst stall req a b | gnt add_a add_b | rsp_valid rsp_data (from the previous edge)
    // single request
    tbl.push_back(mk(0,0,3'b001,A1,B1, 3'b001,16'h0022,16'h10A4, 3'b000,16'h0000));
    tbl.push_back(mk(0,0,3'b000,A1,B1, 3'b000,16'h0000,16'h0000, 3'b001,16'h10C6));
    // idle for 5 cycles, data holds
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,3'b000,A1,B1, 3'b000,16'h0000,16'h0000, 3'b000,16'h10C6));
    // reset with all requesting: no grant while rst is high
    tbl.push_back(mk(1,0,3'b111,A2,B2, 3'b000,16'h0000,16'h0000, 3'b000,16'h10C6));
    // all requesting from ptr=0
    tbl.push_back(mk(0,0,3'b111,A2,B2, 3'b001,16'h0020,16'h0101, 3'b000,16'h0000));
    tbl.push_back(mk(0,0,3'b111,A2,B2, 3'b010,16'hEE00,16'h00FF, 3'b001,16'h0121));
    tbl.push_back(mk(0,0,3'b111,A2,B2, 3'b100,16'h1100,16'h1001, 3'b010,16'hEEFF));
    tbl.push_back(mk(0,0,3'b111,A2,B2, 3'b001,16'h0020,16'h0101, 3'b100,16'h2101));
    tbl.push_back(mk(0,0,3'b000,A2,B2, 3'b000,16'h0000,16'h0000, 3'b001,16'h0121));
    // overflow on requester 2 (ptr=1), so ptr wraps to 0
    tbl.push_back(mk(0,0,3'b100,A3,B3, 3'b100,16'hFFFF,16'h0001, 3'b000,16'h0121));
    // stall for 3 cycles with req=011
    tbl.push_back(mk(0,1,3'b011,A3,B3, 3'b000,16'h0000,16'h0000, 3'b100,16'h0000));
    tbl.push_back(mk(0,1,3'b011,A3,B3, 3'b000,16'h0000,16'h0000, 3'b000,16'h0000));
    tbl.push_back(mk(0,1,3'b011,A3,B3, 3'b000,16'h0000,16'h0000, 3'b000,16'h0000));
    // resume from ptr=0, then 1, then scan 2->0
    tbl.push_back(mk(0,0,3'b011,A3,B3, 3'b001,16'h0001,16'h0002, 3'b000,16'h0000));
    tbl.push_back(mk(0,0,3'b011,A3,B3, 3'b010,16'h0003,16'h0004, 3'b001,16'h0003));
    tbl.push_back(mk(0,0,3'b011,A3,B3, 3'b001,16'h0001,16'h0002, 3'b010,16'h0007));
    tbl.push_back(mk(0,0,3'b000,A3,B3, 3'b000,16'h0000,16'h0000, 3'b001,16'h0003));
    // stall with ptr=1, ptr must be kept
    tbl.push_back(mk(0,1,3'b011,A3,B3, 3'b000,16'h0000,16'h0000, 3'b000,16'h0003));
    tbl.push_back(mk(0,0,3'b011,A3,B3, 3'b010,16'h0003,16'h0004, 3'b000,16'h0003));
    tbl.push_back(mk(0,0,3'b110,A3,B3, 3'b100,16'hFFFF,16'h0001, 3'b010,16'h0007));
    // stall and rst together: rst wins
    tbl.push_back(mk(1,1,3'b111,A3,B3, 3'b000,16'h0000,16'h0000, 3'b100,16'h0000));
    tbl.push_back(mk(0,0,3'b010,A3,B3, 3'b010,16'h0003,16'h0004, 3'b000,16'h0000));

    // Initial reset with all requesting
    rst = 1'b1; stall = 1'b0; req = 3'b111; req_a = A2; req_b = B2;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 3'b000;

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; req = tbl[i].req;
      req_a = tbl[i].a; req_b = tbl[i].b;
      #1;
      chk($sformatf("row%0d_gnt", i),  32'(gnt),       32'(tbl[i].xg));
      chk($sformatf("row%0d_add_a", i), 32'(add_a),    32'(tbl[i].xa));
      chk($sformatf("row%0d_add_b", i), 32'(add_b),    32'(tbl[i].xb));
      chk($sformatf("row%0d_rsp_v", i), 32'(rsp_valid), 32'(tbl[i].xrv));
      chk($sformatf("row%0d_rsp_d", i), 32'(rsp_data),  32'(tbl[i].xrd));
    end

    // Reset mid-operation. ptr=2 here: req1 is granted, and the next edge resets
    // before the response can be consumed.
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; req = 3'b010; req_a = A3; req_b = B3;
    #1;
    chk("mid_rsp_v_prev", 32'(rsp_valid), 32'h2);
    chk("mid_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    rst = 1'b1; req = 3'b111;
    #1;
    chk("mid_gnt_in_rst", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 3'b111;
    #1;
    chk("mid_rsp_v", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_d", 32'(rsp_data), 32'h0);
    chk("mid_gnt_after", 32'(gnt), 32'h1);

    // Operands change after the grant; the response must keep the sampled sum.
    @(negedge clk);
    req = 3'b001; req_a = {32'h0, 16'h1234}; req_b = {32'h0, 16'h1111};
    #1;
    chk("op_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 3'b000; req_a = '0; req_b = '0;
    #1;
    chk("op_rsp_v", 32'(rsp_valid), 32'h1);
    chk("op_rsp_d", 32'(rsp_data), 32'h2345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
